// File: rtl/controle_es_pkg.sv
// Shared definitions for the I/O handshake controller.
// Holds the FSM state encoding and the default debounce length.
// Imported by controle_es and filtro_botao.
package controle_es_pkg;

    // Cycles a synchronized button level must stay stable before it is accepted.
    localparam logic [15:0] DEBOUNCE_PADRAO = 16'd4;

    typedef enum logic [1:0] {
        OCIOSO        = 2'd0,
        ESPERA_BOTAO  = 2'd1,
        PULSO         = 2'd2,
        ESPERA_SOLTAR = 2'd3
    } estado_t;

endpackage

// File: rtl/filtro_botao.sv
// Two-flop synchronizer followed by a stable-count debounce filter.
// Level changes DEBOUNCE_CICLOS cycles after the synchronized input settles, plus 2 sync cycles.
// No backpressure; subida_o flags the edge on which the level will switch to high.
module filtro_botao
    import controle_es_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CICLOS = DEBOUNCE_PADRAO
) (
    input  logic clock,
    input  logic reset,
    input  logic botao_i,
    output logic nivel_o,
    output logic subida_o
);

    localparam logic [15:0] LIMITE = DEBOUNCE_CICLOS - 16'd1;

    logic [1:0]  sinc_q;
    logic        nivel_q;
    logic [15:0] cnt_q;
    logic        sinc;

    assign sinc = sinc_q[1];

    // Synchronize the raw button and count consecutive samples that differ from the accepted level.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sinc_q  <= 2'b00;
            nivel_q <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            sinc_q <= {sinc_q[0], botao_i};
            if (sinc != nivel_q) begin
                if (cnt_q == LIMITE) begin
                    nivel_q <= sinc;
                    cnt_q   <= 16'd0;
                end else begin
                    cnt_q <= cnt_q + 16'd1;
                end
            end else begin
                // A sample equal to the accepted level means the input bounced back.
                cnt_q <= 16'd0;
            end
        end
    end

    // Rising edge is announced on the same clock edge that accepts the new level.
    always_comb begin
        subida_o = sinc & ~nivel_q & (cnt_q == LIMITE);
    end

    assign nivel_o = nivel_q;

endmodule

// File: rtl/controle_es.sv
// Handshake between the control unit's in/out instructions and a confirm push-button.
// sinal pulses 2 + DEBOUNCE_CICLOS cycles after a clean press; all outputs are registered or state-decoded.
// A request waits in ESPERA_BOTAO until pressed; the button must be released before the next request.
module controle_es
    import controle_es_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CICLOS = DEBOUNCE_PADRAO
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in,
    input  logic        out,
    input  logic [31:0] dado_saida,
    input  logic [15:0] chaves,
    input  logic        botao,
    output logic        sinal,
    output logic [31:0] dado_entrada,
    output logic [31:0] display,
    output logic        aguardando
);

    estado_t     estado_q, estado_d;
    logic [31:0] entrada_q, entrada_d;
    logic [31:0] display_q, display_d;
    logic        nivel;
    logic        subida;

    filtro_botao #(
        .DEBOUNCE_CICLOS (DEBOUNCE_CICLOS)
    ) u_filtro (
        .clock    (clock),
        .reset    (reset),
        .botao_i  (botao),
        .nivel_o  (nivel),
        .subida_o (subida)
    );

    // State and data registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q  <= OCIOSO;
            entrada_q <= 32'd0;
            display_q <= 32'd0;
        end else begin
            estado_q  <= estado_d;
            entrada_q <= entrada_d;
            display_q <= display_d;
        end
    end

    // Next state and data capture; data registers hold unless a load edge is taken.
    always_comb begin
        estado_d  = estado_q;
        entrada_d = entrada_q;
        display_d = display_q;
        case (estado_q)
            OCIOSO: begin
                // A button still seen high belongs to the previous request.
                if ((in || out) && !nivel) begin
                    estado_d = ESPERA_BOTAO;
                    if (out && !in) begin
                        display_d = dado_saida;
                    end
                end
            end
            ESPERA_BOTAO: begin
                if (!in && !out) begin
                    estado_d = OCIOSO;
                end else if (subida) begin
                    estado_d = PULSO;
                    if (in) begin
                        entrada_d = {16'b0, chaves};
                    end
                end
            end
            PULSO: begin
                estado_d = ESPERA_SOLTAR;
            end
            ESPERA_SOLTAR: begin
                if (!nivel) begin
                    estado_d = OCIOSO;
                end
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    assign sinal        = (estado_q == PULSO);
    assign aguardando   = (estado_q == ESPERA_BOTAO);
    assign dado_entrada = entrada_q;
    assign display      = display_q;

endmodule

// File: tb/tb_controle_es.sv
module tb_controle_es;

    logic        clock;
    logic        reset;
    logic        in;
    logic        out;
    logic [31:0] dado_saida;
    logic [15:0] chaves;
    logic        botao;
    logic        sinal;
    logic [31:0] dado_entrada;
    logic [31:0] display;
    logic        aguardando;

    int n_checks = 0;
    int n_pass   = 0;
    int npulsos  = 0;
    int base;

    controle_es #(
        .DEBOUNCE_CICLOS (16'd4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .in           (in),
        .out          (out),
        .dado_saida   (dado_saida),
        .chaves       (chaves),
        .botao        (botao),
        .sinal        (sinal),
        .dado_entrada (dado_entrada),
        .display      (display),
        .aguardando   (aguardando)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Count every cycle in which sinal is high.
    always @(posedge clock) begin
        if (sinal === 1'b1) npulsos = npulsos + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Press, let the pulse occur, withdraw the request and release.
    task automatic pressiona();
        botao = 1'b1;
        repeat (8) step();
        in    = 1'b0;
        out   = 1'b0;
        botao = 1'b0;
        repeat (10) step();
    endtask

    initial begin
        reset = 1'b0; in = 1'b0; out = 1'b0; botao = 1'b0;
        dado_saida = 32'd0; chaves = 16'd0;
        step(); step();
        chk("rst_sinal", 32'(sinal), 32'd0);
        chk("rst_aguard", 32'(aguardando), 32'd0);
        chk("rst_entrada", dado_entrada, 32'd0);
        chk("rst_display", display, 32'd0);
        reset = 1'b1;
        step();

        // Clean press on an in request: pulse exactly 6 cycles after the press.
        in = 1'b1; chaves = 16'hA5C3;
        step();
        chk("in_aguard", 32'(aguardando), 32'd1);
        botao = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("in_lat_k%0d", k), 32'(sinal), 32'(k == 6));
            if (k == 6) begin
                chk("in_entrada", dado_entrada, 32'h0000A5C3);
                chk("in_aguard_pulso", 32'(aguardando), 32'd0);
                in = 1'b0;
            end
        end
        chk("in_aguard_after", 32'(aguardando), 32'd0);
        botao = 1'b0;
        repeat (10) step();
        chk("in_one_pulse", 32'(npulsos), 32'd1);
        chk("in_hold", dado_entrada, 32'h0000A5C3);

        // Out request: display latched at request time, later changes ignored.
        base = npulsos;
        out = 1'b1; dado_saida = 32'hDEADBEEF;
        step();
        chk("out_display_early", display, 32'hDEADBEEF);
        dado_saida = 32'h12345678;
        step();
        pressiona();
        chk("out_display", display, 32'hDEADBEEF);
        chk("out_one_pulse", 32'(npulsos - base), 32'd1);
        chk("out_entrada_hold", dado_entrada, 32'h0000A5C3);

        // Simultaneous in and out: capture only, display untouched.
        base = npulsos;
        in = 1'b1; out = 1'b1; chaves = 16'hBEEF; dado_saida = 32'h11111111;
        step(); step();
        pressiona();
        chk("both_entrada", dado_entrada, 32'h0000BEEF);
        chk("both_display", display, 32'hDEADBEEF);
        chk("both_one_pulse", 32'(npulsos - base), 32'd1);

        // Bouncing press: only the final stable level counts.
        base = npulsos;
        in = 1'b1; chaves = 16'h1234;
        step(); step();
        botao = 1'b1; step();
        botao = 1'b0; step();
        botao = 1'b1; step();
        step();
        botao = 1'b0; step();
        step(); step();
        chk("bounce_no_pulse", 32'(npulsos - base), 32'd0);
        botao = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("bounce_lat_k%0d", k), 32'(sinal), 32'(k == 6));
        end
        in = 1'b0; botao = 1'b0;
        repeat (10) step();
        chk("bounce_one_pulse", 32'(npulsos - base), 32'd1);
        chk("bounce_entrada", dado_entrada, 32'h00001234);

        // Back-to-back requests with the button held: second needs a new press.
        base = npulsos;
        in = 1'b1; chaves = 16'h0F0F;
        step(); step();
        botao = 1'b1;
        repeat (8) step();
        chk("b2b_first", 32'(npulsos - base), 32'd1);
        chaves = 16'h00FF;
        repeat (10) step();
        chk("b2b_held_no_pulse", 32'(npulsos - base), 32'd1);
        chk("b2b_held_not_wait", 32'(aguardando), 32'd0);
        chk("b2b_held_entrada", dado_entrada, 32'h00000F0F);
        botao = 1'b0;
        repeat (8) step();
        chk("b2b_release_wait", 32'(aguardando), 32'd1);
        chk("b2b_release_no_pulse", 32'(npulsos - base), 32'd1);
        pressiona();
        chk("b2b_second", 32'(npulsos - base), 32'd2);
        chk("b2b_entrada", dado_entrada, 32'h000000FF);

        // Reset in the middle of a wait aborts everything.
        base = npulsos;
        in = 1'b1; chaves = 16'h5555;
        step(); step();
        botao = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        #1;
        chk("mid_rst_sinal", 32'(sinal), 32'd0);
        chk("mid_rst_aguard", 32'(aguardando), 32'd0);
        chk("mid_rst_entrada", dado_entrada, 32'd0);
        chk("mid_rst_display", display, 32'd0);
        in = 1'b0; botao = 1'b0;
        step(); step();
        reset = 1'b1;
        repeat (10) step();
        chk("mid_rst_no_pulse", 32'(npulsos - base), 32'd0);

        // Withdrawn request returns to idle with no pulse.
        in = 1'b1;
        step(); step();
        chk("withdraw_wait", 32'(aguardando), 32'd1);
        in = 1'b0;
        step();
        chk("withdraw_idle", 32'(aguardando), 32'd0);
        repeat (8) step();
        chk("withdraw_no_pulse", 32'(npulsos - base), 32'd0);

        // Button held across reset release is a new press only after the full filter delay.
        botao = 1'b1; chaves = 16'h00AA;
        reset = 1'b0;
        step(); step();
        in = 1'b1;
        reset = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("held_rst_k%0d", k), 32'(sinal), 32'(k == 6));
        end
        in = 1'b0; botao = 1'b0;
        repeat (10) step();
        chk("held_rst_entrada", dado_entrada, 32'h000000AA);
        chk("held_rst_one_pulse", 32'(npulsos - base), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/controle_es.md
CONTROLE_ES -- requirements
Module: controle_es

Interface
REQ-001 Parameter DEBOUNCE_CICLOS, default 16'd4, consecutive stable cycles required before a button level is accepted.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 in  input  1  input request from the control unit.
REQ-005 out  input  1  output request from the control unit.
REQ-006 dado_saida  input  32  register value to display on an out request.
REQ-007 chaves  input  16  raw switch bank, sampled on an in request.
REQ-008 botao  input  1  raw confirm push-button, asynchronous, active-high.
REQ-009 sinal  output  1  completion pulse back to the control unit.
REQ-010 dado_entrada  output  32  captured switch value, zero-extended.
REQ-011 display  output  32  latched output value.
REQ-012 aguardando  output  1  high while a request is waiting for the button.

Function
REQ-013 botao SHALL pass through a two-flop synchronizer, then a debounce filter; accepted level changes only after DEBOUNCE_CICLOS consecutive equal synchronized samples; any change restarts the count.
REQ-014 FSM states: OCIOSO, ESPERA_BOTAO, PULSO, ESPERA_SOLTAR.
REQ-015 OCIOSO: if in or out is high and the filtered button is low -> ESPERA_BOTAO; if the filtered button is high -> stay.
REQ-016 On the OCIOSO->ESPERA_BOTAO edge with out=1, display SHALL load dado_saida in that same edge.
REQ-017 ESPERA_BOTAO: aguardando=1; on a filtered rising button edge -> PULSO; if in and out are both low -> OCIOSO with no pulse (request withdrawn).
REQ-018 On the ESPERA_BOTAO->PULSO edge with in=1, dado_entrada SHALL load {16'b0, chaves}.
REQ-019 PULSO: sinal=1 for exactly one cycle; aguardando=0; unconditionally -> ESPERA_SOLTAR.
REQ-020 ESPERA_SOLTAR: sinal=0; -> OCIOSO once the filtered button is low; a new request SHALL NOT be accepted until then, so consecutive in/out instructions each require a separate press.
REQ-021 Simultaneous in and out: in SHALL take priority for capture; display is not loaded.
REQ-022 dado_entrada and display SHALL hold their values between requests.
REQ-023 Latency: sinal asserts on the cycle after the filtered press is accepted, which is 2 + DEBOUNCE_CICLOS cycles after a clean press.
REQ-024 No output SHALL depend combinationally on botao or chaves.

Reset
REQ-025 With reset low: state=OCIOSO; sinal=0, aguardando=0, dado_entrada=0, display=0; synchronizer, filter level and debounce counter cleared.
REQ-026 Reset asserted mid-wait or mid-pulse SHALL abort immediately, with no sinal after release.
REQ-027 After reset release, a button already held SHALL be treated as a new press only after DEBOUNCE_CICLOS stable cycles.

Structure
REQ-028 State encoding and the DEBOUNCE_CICLOS default SHALL live in the shared package controle_es_pkg.
REQ-029 Synchronizer plus debounce SHALL be one sub-module, filtro_botao (botao in, clean level out).

Verification (DEBOUNCE_CICLOS=4)
REQ-030 Stimulus: in=1, chaves=16'hA5C3, clean press. Required response: one-cycle sinal 6 cycles after the press, dado_entrada=32'h0000A5C3, aguardando low afterwards.
REQ-031 Stimulus: out=1 with dado_saida=32'hDEADBEEF, then dado_saida changes before the press. Required response: display=32'hDEADBEEF, one sinal pulse.
REQ-032 Stimulus: bouncing press (1,0,1,1,0, then stable 1). Required response: exactly one sinal, only after 4 stable cycles.
REQ-033 Stimulus: two back-to-back in requests, button held through both. Required response: the second request gets no sinal until the button is released and pressed again.
REQ-034 Stimulus: reset asserted during ESPERA_BOTAO. Required response: all outputs 0 and no sinal; a withdrawn request (in dropped) returns to OCIOSO with no sinal.
